// File: rtl/top2_frame_scheduler_if.sv
// Request-stream and result-port bundle for the frame scheduler.
// The slave modport is the scheduler side; the master modport is the sources plus the collector.
interface top2_frame_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned COUNT_W    = 16
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          res_valid;
    logic                          res_ready;
    logic [ID_W-1:0]               res_id;
    logic [DATA_WIDTH-1:0]         res_largest;
    logic [DATA_WIDTH-1:0]         res_second;
    logic [COUNT_W-1:0]            res_count;
    logic                          res_short;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_id, res_largest, res_second, res_count, res_short
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_id, res_largest, res_second, res_count, res_short
    );
endinterface

// File: rtl/top2_frame_scheduler.sv
// Round-robin frame scheduler that shares one largest/second-largest tracker
// between NUM_REQ sample streams. It reports {id, largest, second, count} once per frame.
module top2_frame_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    top2_frame_scheduler_if.slave  bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_grant;
    logic [ID_W-1:0]        r_last_grant;
    logic [ID_W-1:0]        w_rr_pick;
    logic                   w_any_valid;
    logic                   w_accept;
    logic                   w_beat_last;
    logic [DATA_WIDTH-1:0]  w_beat;
    logic [DATA_WIDTH-1:0]  r_largest;
    logic [DATA_WIDTH-1:0]  r_second;
    logic [DATA_WIDTH-1:0]  w_new_largest;
    logic [DATA_WIDTH-1:0]  w_new_second;
    logic [COUNT_W-1:0]     r_count;
    logic [COUNT_W-1:0]     w_new_count;

    logic [NUM_REQ-1:0]     r_req_ready;
    logic                   r_res_valid;
    logic [ID_W-1:0]        r_res_id;
    logic [DATA_WIDTH-1:0]  r_res_largest;
    logic [DATA_WIDTH-1:0]  r_res_second;
    logic [COUNT_W-1:0]     r_res_count;
    logic                   r_res_short;

    assign bus.req_ready   = r_req_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_id      = r_res_id;
    assign bus.res_largest = r_res_largest;
    assign bus.res_second  = r_res_second;
    assign bus.res_count   = r_res_count;
    assign bus.res_short   = r_res_short;

    // Round-robin pick: the first valid requester after last_grant. The descending scan lets the nearest one win.
    always_comb begin
        w_any_valid = |bus.req_valid;
        w_rr_pick   = r_last_grant;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (bus.req_valid[j] && (j == ((int'(r_last_grant) + k) % int'(NUM_REQ)))) begin
                    w_rr_pick = ID_W'(j);
                end
            end
        end
    end

    // Granted lane mux and the tracker update for the current beat.
    always_comb begin
        w_beat      = '0;
        w_beat_last = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_grant == ID_W'(i)) begin
                w_beat      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_beat_last = bus.req_last[i];
            end
        end
        w_accept      = |(r_req_ready & bus.req_valid);
        w_new_largest = r_largest;
        w_new_second  = r_second;
        if (w_beat >= r_largest) begin
            w_new_largest = w_beat;
            w_new_second  = r_largest;
        end else if (w_beat >= r_second) begin
            w_new_second  = w_beat;
        end
        w_new_count = (r_count == '1) ? r_count : r_count + COUNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_valid)                   w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && w_beat_last)       w_state_nxt = S_DONE;
            S_DONE:   if (r_res_valid && bus.res_ready)  w_state_nxt = S_IDLE;
            default:                                     w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, tracker and result registers. The result is loaded on the last beat, including that beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_grant       <= '0;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_largest     <= '0;
            r_second      <= '0;
            r_count       <= '0;
            r_req_ready   <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_largest <= '0;
            r_res_second  <= '0;
            r_res_count   <= '0;
            r_res_short   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_largest <= '0;
                    r_second  <= '0;
                    r_count   <= '0;
                    if (w_any_valid) begin
                        r_grant     <= w_rr_pick;
                        r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_rr_pick;
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_largest <= w_new_largest;
                        r_second  <= w_new_second;
                        r_count   <= w_new_count;
                        if (w_beat_last) begin
                            r_req_ready   <= '0;
                            r_res_valid   <= 1'b1;
                            r_res_id      <= r_grant;
                            r_res_largest <= w_new_largest;
                            r_res_second  <= w_new_second;
                            r_res_count   <= w_new_count;
                            r_res_short   <= (w_new_count < COUNT_W'(2));
                        end
                    end
                end
                S_DONE: begin
                    if (r_res_valid && bus.res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                    r_req_ready <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_top2_frame_scheduler.sv
// Directed bench for top2_frame_scheduler. A table of frames runs first, followed by
// hand-written sequences for arbitration order, result back-pressure and mid-frame reset.
module tb_top2_frame_scheduler;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 4;
    localparam int unsigned CW  = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    top2_frame_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .COUNT_W(CW)) bus ();

    top2_frame_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .COUNT_W(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [1:0]       id;
        logic [2:0]       n;
        logic [3:0][31:0] d;
        logic [31:0]      exp_l;
        logic [31:0]      exp_s;
        logic [15:0]      exp_c;
        logic             exp_short;
    } frame_t;

    frame_t tbl [7];

    function automatic frame_t mk(input int id, input int n,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3,
                                  input logic [31:0] el, input logic [31:0] es,
                                  input int ec, input bit sh);
        frame_t f;
        f.id        = 2'(id);
        f.n         = 3'(n);
        f.d[0]      = d0;
        f.d[1]      = d1;
        f.d[2]      = d2;
        f.d[3]      = d3;
        f.exp_l     = el;
        f.exp_s     = es;
        f.exp_c     = 16'(ec);
        f.exp_short = sh;
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Bounded wait until requester i sees ready. Ready only changes at edges.
    task automatic wait_ready(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.req_ready[i]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Drive the n beats of one frame. The task returns one sample after the last beat is accepted.
    task automatic send_frame(input frame_t f);
        bit ok;
        int id;
        id = int'(f.id);
        for (int b = 0; b < int'(f.n); b++) begin
            set_data(id, f.d[b]);
            bus.req_last[id]  = (b == int'(f.n) - 1);
            bus.req_valid[id] = 1'b1;
            wait_ready(id, 20, ok);
            if (!ok) begin
                chk("grant_timeout", 64'(ok), 64'd1);
                break;
            end
            if (b == 0) chk("ready_onehot", 64'(bus.req_ready), 64'(4'b0001 << id));
            step();
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        bus.res_ready = 1'b1;
        send_frame(f);
        chk("res_valid",   64'(bus.res_valid),   64'd1);
        chk("res_id",      64'(bus.res_id),      64'(f.id));
        chk("res_largest", 64'(bus.res_largest), 64'(f.exp_l));
        chk("res_second",  64'(bus.res_second),  64'(f.exp_s));
        chk("res_count",   64'(bus.res_count),   64'(f.exp_c));
        chk("res_short",   64'(bus.res_short),   64'(f.exp_short));
        chk("ready_done",  64'(bus.req_ready),   64'd0);
        step();
        chk("res_valid_drop", 64'(bus.res_valid), 64'd0);
    endtask

    // At most one ready bit may ever be set.
    always @(negedge clk) begin
        if (resetn && ((bus.req_ready & (bus.req_ready - 4'd1)) != 4'd0)) begin
            n_total++;
            $display("FAIL ready_multi: got %b expected one-hot or zero", bus.req_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int g;
        int exp_order [4];
        frame_t f4;

        tbl[0] = mk(0, 3, 32'd3, 32'd9, 32'd7, 32'd0, 32'd9, 32'd7, 3, 1'b0);
        tbl[1] = mk(1, 3, 32'd5, 32'd5, 32'd2, 32'd0, 32'd5, 32'd5, 3, 1'b0);
        tbl[2] = mk(3, 1, 32'd42, 32'd0, 32'd0, 32'd0, 32'd42, 32'd0, 1, 1'b1);
        tbl[3] = mk(2, 4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd3, 4, 1'b0);
        tbl[4] = mk(0, 4, 32'd10, 32'd8, 32'd8, 32'd1, 32'd10, 32'd8, 4, 1'b0);
        tbl[5] = mk(1, 2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
        tbl[6] = mk(2, 3, 32'd7, 32'd7, 32'd7, 32'd0, 32'd7, 32'd7, 3, 1'b0);
        exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 0; exp_order[3] = 2;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;
        resetn = 1'b0;
        step(); step(); step();
        chk("rst_ready",   64'(bus.req_ready),   64'd0);
        chk("rst_valid",   64'(bus.res_valid),   64'd0);
        chk("rst_id",      64'(bus.res_id),      64'd0);
        chk("rst_largest", 64'(bus.res_largest), 64'd0);
        chk("rst_count",   64'(bus.res_count),   64'd0);
        resetn = 1'b1;

        // Requesters 0 and 2 valid from reset, each sending back-to-back 2-beat frames.
        set_data(0, 32'd1);  bus.req_valid[0] = 1'b1;
        set_data(2, 32'd10); bus.req_valid[2] = 1'b1;
        for (int fr = 0; fr < 4; fr++) begin
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (bus.req_ready != 4'd0) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            chk("t3_grant_seen", 64'(ok), 64'd1);
            chk("t3_grant_order", 64'(bus.req_ready), 64'(4'b0001 << exp_order[fr]));
            g = bus.req_ready[2] ? 2 : 0;
            step();
            set_data(g, (g == 0) ? 32'd2 : 32'd20);
            bus.req_last[g] = 1'b1;
            step();
            bus.req_last[g] = 1'b0;
            set_data(g, (g == 0) ? 32'd1 : 32'd10);
            if (fr == 3) begin
                bus.req_valid[0] = 1'b0;
                bus.req_valid[2] = 1'b0;
            end
            chk("t3_res_valid",   64'(bus.res_valid),   64'd1);
            chk("t3_res_id",      64'(bus.res_id),      64'(exp_order[fr]));
            chk("t3_res_largest", 64'(bus.res_largest), (exp_order[fr] == 0) ? 64'd2 : 64'd20);
        end
        step();
        step();

        for (int t = 0; t < 7; t++) run_frame(tbl[t]);

        // The result is held under back-pressure while another requester waits.
        bus.res_ready = 1'b0;
        f4 = mk(1, 2, 32'd4, 32'd6, 32'd0, 32'd0, 32'd6, 32'd4, 2, 1'b0);
        send_frame(f4);
        set_data(2, 32'd5);
        bus.req_last[2]  = 1'b1;
        bus.req_valid[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid",   64'(bus.res_valid),   64'd1);
            chk("t4_hold_largest", 64'(bus.res_largest), 64'd6);
            chk("t4_hold_second",  64'(bus.res_second),  64'd4);
            chk("t4_hold_count",   64'(bus.res_count),   64'd2);
            chk("t4_hold_ready",   64'(bus.req_ready),   64'd0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        chk("t4_release_valid", 64'(bus.res_valid), 64'd0);
        chk("t4_idle_ready",    64'(bus.req_ready), 64'd0);
        step();
        chk("t4_next_grant",    64'(bus.req_ready), 64'd4);
        step();
        bus.req_valid[2] = 1'b0;
        bus.req_last[2]  = 1'b0;
        chk("t4_res_id",    64'(bus.res_id),      64'd2);
        chk("t4_res_l",     64'(bus.res_largest), 64'd5);
        chk("t4_res_short", 64'(bus.res_short),   64'd1);
        step();
        step();

        // A reset after two beats of a frame abandons that frame.
        set_data(1, 32'd3);
        bus.req_valid[1] = 1'b1;
        wait_ready(1, 20, ok);
        chk("t6_grant", 64'(ok), 64'd1);
        step();
        set_data(1, 32'd8);
        step();
        resetn = 1'b0;
        step();
        chk("t6_ready",   64'(bus.req_ready),   64'd0);
        chk("t6_valid",   64'(bus.res_valid),   64'd0);
        chk("t6_id",      64'(bus.res_id),      64'd0);
        chk("t6_largest", 64'(bus.res_largest), 64'd0);
        chk("t6_second",  64'(bus.res_second),  64'd0);
        chk("t6_count",   64'(bus.res_count),   64'd0);
        chk("t6_short",   64'(bus.res_short),   64'd0);
        resetn = 1'b1;
        set_data(0, 32'd11);
        bus.req_last[0]  = 1'b1;
        bus.req_valid[0] = 1'b1;
        step();
        chk("t6_first_grant", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;
        chk("t6_res_valid", 64'(bus.res_valid),   64'd1);
        chk("t6_res_id",    64'(bus.res_id),      64'd0);
        chk("t6_res_l",     64'(bus.res_largest), 64'd11);
        step();
        chk("t6_res_drop",  64'(bus.res_valid),   64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
